screen_seq_ctrl: RTL and testbench
==================================

SCREEN_SEQ_CTRL -- requirements
Module: screen_seq_ctrl

Interface
REQ-001 The block SHALL have parameter BLINK_FRAMES, default 32: frames per half-period of the "press start" blink.
REQ-002 The block SHALL have parameter RESULT_FRAMES, default 180: frames the result screen is held before returning to start.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system (pixel) clock.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port vsync_in, input, 1 bit: vsync from the VGA timing chain, asynchronous to nothing, sampled on clk.
REQ-006 The block SHALL have port btn_start, input, 1 bit: raw start/confirm button level, asynchronous.
REQ-007 The block SHALL have port game_over, input, 1 bit: single-cycle pulse from game logic.
REQ-008 The block SHALL have port screen_sel, output, 2 bits: selects the char overlay (start, game or result) driving the text datapath.
REQ-009 The block SHALL have port game_en, output, 1 bit: enables game logic.
REQ-010 The block SHALL have port blink_on, output, 1 bit: text visibility for the blinking prompt.
REQ-011 The block SHALL have port frame_tick, output, 1 bit: one-cycle pulse per frame.

Function
REQ-012 btn_start SHALL pass through a 2-flop synchroniser; a press event is a rising edge of the synchronised level, with 3 cycles latency from the pin.
REQ-013 frame_tick SHALL pulse for one cycle on each rising edge of registered vsync_in.
REQ-014 The FSM states SHALL be START, GAME and RESULT; screen_sel encodes them as 0, 1 and 2, and value 3 never occurs.
REQ-015 START SHALL go to GAME on a press event; GAME SHALL go to RESULT on game_over; RESULT SHALL go to START on a press event or when the hold counter reaches RESULT_FRAMES-1 at a frame_tick.
REQ-016 A transition request SHALL be latched as pending and the state change applied only on the next frame_tick, so that screen_sel changes only at a frame boundary.
REQ-017 Where a request and a frame_tick coincide in the same cycle, the change SHALL apply on that cycle.
REQ-018 A second request while one is pending SHALL be ignored, and the first pending target wins.
REQ-019 game_over SHALL be ignored outside GAME, and press events SHALL be ignored in GAME.
REQ-020 game_en SHALL be 1 exactly when the state is GAME; all outputs SHALL be registered.
REQ-021 The blink counter SHALL count frame_ticks in START, toggle blink_on at BLINK_FRAMES-1 and wrap to 0; outside START, blink_on SHALL be 1 and the counter 0.
REQ-022 The hold counter SHALL clear on entry to RESULT, saturate at RESULT_FRAMES-1 and be unused elsewhere.
REQ-023 Counter widths SHALL be $clog2 of their parameter, with no overflow possible.

Reset
REQ-024 On rst, the state SHALL be START and outputs SHALL be screen_sel=0, game_en=0, blink_on=1 and frame_tick=0.
REQ-025 On rst, all counters, the pending flag and the synchroniser/edge registers SHALL clear.
REQ-026 Reset asserted mid-game SHALL override any pending request or simultaneous event in that cycle.
REQ-027 After reset, a button held high SHALL NOT generate a press event until it is released and pressed again.

Structure
REQ-028 A shared package SHALL hold the state enum (START, GAME, RESULT) and the screen_sel encodings, for use by the char overlay mux.
REQ-029 One sub-module SHALL implement the synchroniser plus rising-edge detector, btn_sync_edge, used for btn_start.
REQ-030 The frame-edge detect, FSM and counters SHALL reside in screen_seq_ctrl.

Verification
REQ-031 Reset then idle for 3 frames -> screen_sel=0, game_en=0, blink_on toggles after 32 frame_ticks.
REQ-032 Press btn_start mid-frame -> screen_sel stays 0 until the next vsync rising edge, then becomes 1 with game_en=1 on the same cycle.
REQ-033 In GAME, pulse game_over on the same cycle as frame_tick -> screen_sel=2 that cycle; a press event in GAME -> no change.
REQ-034 In RESULT with no press -> return to screen_sel=0 after exactly 180 frame_ticks; with a press at frame 10 -> screen_sel=0 at frame 11.
REQ-035 Assert rst while in GAME with a pending game_over -> START next cycle, game_en=0, no transition to RESULT.
REQ-036 Hold btn_start high through reset -> no press event until it is released and pressed again.

Source files
------------

// File: rtl/screen_seq_ctrl_pkg.sv
// Shared definitions for the screen sequencer and the char overlay mux:
// the screen state enum, the screen_sel encodings and small helpers.
package screen_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_GAME   = 2'd1,
    ST_RESULT = 2'd2
  } state_e;

  // Overlay select codes seen by the text datapath; 2'd3 is never produced.
  localparam logic [1:0] SEL_START  = 2'd0;
  localparam logic [1:0] SEL_GAME   = 2'd1;
  localparam logic [1:0] SEL_RESULT = 2'd2;

  // Map a screen state onto the overlay select code.
  function automatic logic [1:0] state_to_sel(input state_e s);
    logic [1:0] sel;
    case (s)
      ST_GAME:   sel = SEL_GAME;
      ST_RESULT: sel = SEL_RESULT;
      default:   sel = SEL_START;
    endcase
    return sel;
  endfunction

  // Counter width for a modulus n; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser plus registered rising-edge detector for a raw
// button level. The pulse appears three clocks after the pin rises. After
// reset a rising edge is only reported once a genuine low level has been
// seen, so a button held through reset does not fire until re-pressed.
module btn_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic       r_meta;
  logic       r_sync;
  logic       r_sync_d;
  logic [1:0] r_fill;
  logic       r_armed;
  logic       r_rise;

  // Synchronise, delay for edge detect, and arm only after a real low sample
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
      r_fill   <= 2'b00;
      r_armed  <= 1'b0;
      r_rise   <= 1'b0;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
      // r_fill[1] marks r_sync as holding a pin sample rather than reset value
      r_fill   <= {r_fill[0], 1'b1};
      if (r_fill[1] && !r_sync) begin
        r_armed <= 1'b1;
      end
      r_rise   <= r_armed & r_sync & ~r_sync_d;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/screen_seq_ctrl.sv
// Screen sequencer: START -> GAME -> RESULT -> START. Transition requests
// are held pending and applied on a frame_tick so that the overlay select
// only changes at a frame boundary. Also owns the blink and hold counters.
module screen_seq_ctrl
  import screen_seq_ctrl_pkg::*;
#(
  parameter int BLINK_FRAMES  = 32,
  parameter int RESULT_FRAMES = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync_in,
  input  logic       btn_start,
  input  logic       game_over,
  output logic [1:0] screen_sel,
  output logic       game_en,
  output logic       blink_on,
  output logic       frame_tick
);

  localparam int BLINK_W = cnt_width(BLINK_FRAMES);
  localparam int HOLD_W  = cnt_width(RESULT_FRAMES);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESULT_FRAMES - 1);

  logic               w_press;
  logic               w_tick;
  logic               w_req;
  state_e             w_req_tgt;
  logic               w_apply;
  state_e             w_next;

  logic               r_vs_d1;
  logic               r_vs_d2;
  logic               r_frame_tick;
  state_e             r_state;
  logic               r_pend;
  state_e             r_pend_tgt;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_on;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [1:0]         r_screen_sel;
  logic               r_game_en;

  btn_sync_edge u_btn_sync_edge (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_async (btn_start),
    .o_rise  (w_press)
  );

  // Register vsync and keep a delayed copy to find its rising edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_d1      <= 1'b0;
      r_vs_d2      <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_vs_d1      <= vsync_in;
      r_vs_d2      <= r_vs_d1;
      r_frame_tick <= w_tick;
    end
  end

  assign w_tick = r_vs_d1 & ~r_vs_d2;

  // Decode this cycle's transition request for the current state
  always_comb begin
    w_req     = 1'b0;
    w_req_tgt = r_state;
    case (r_state)
      ST_START: begin
        if (w_press) begin
          w_req     = 1'b1;
          w_req_tgt = ST_GAME;
        end
      end
      ST_GAME: begin
        if (game_over) begin
          w_req     = 1'b1;
          w_req_tgt = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (w_press || (w_tick && (r_hold_cnt == HOLD_LAST))) begin
          w_req     = 1'b1;
          w_req_tgt = ST_START;
        end
      end
      default: begin
        w_req     = 1'b0;
        w_req_tgt = ST_START;
      end
    endcase
  end

  // An existing pending target wins over a new request in the same frame
  always_comb begin
    w_apply = w_tick & (r_pend | w_req);
    w_next  = r_pend ? r_pend_tgt : w_req_tgt;
  end

  // Screen FSM with pending request, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_START;
      r_pend       <= 1'b0;
      r_pend_tgt   <= ST_START;
      r_blink_cnt  <= '0;
      r_blink_on   <= 1'b1;
      r_hold_cnt   <= '0;
      r_screen_sel <= SEL_START;
      r_game_en    <= 1'b0;
    end else begin
      if (w_apply) begin
        r_state      <= w_next;
        r_pend       <= 1'b0;
        r_screen_sel <= state_to_sel(w_next);
        r_game_en    <= (w_next == ST_GAME);
      end else if (w_req && !r_pend) begin
        r_pend     <= 1'b1;
        r_pend_tgt <= w_req_tgt;
      end

      // Blink runs only while START is held; text is steady otherwise
      if (w_apply || (r_state != ST_START)) begin
        r_blink_cnt <= '0;
        r_blink_on  <= 1'b1;
      end else if (w_tick) begin
        if (r_blink_cnt == BLINK_LAST) begin
          r_blink_cnt <= '0;
          r_blink_on  <= ~r_blink_on;
        end else begin
          r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
        end
      end

      // Hold counter restarts on entering RESULT and saturates at the last frame
      if (w_apply || (r_state != ST_RESULT)) begin
        r_hold_cnt <= '0;
      end else if (w_tick && (r_hold_cnt != HOLD_LAST)) begin
        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      end
    end
  end

  assign screen_sel = r_screen_sel;
  assign game_en    = r_game_en;
  assign blink_on   = r_blink_on;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_screen_seq_ctrl.sv
// Directed bench for screen_seq_ctrl: expected screen_sel per frame is queued
// when a frame is driven and compared when the frame_tick pulse appears.
module tb_screen_seq_ctrl;
  import screen_seq_ctrl_pkg::*;

  localparam int GAP = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync_in;
  logic       btn_start;
  logic       game_over;
  logic [1:0] screen_sel;
  logic       game_en;
  logic       blink_on;
  logic       frame_tick;

  logic [1:0] exp_q[$];
  int         n_assert = 0;
  int         n_fail   = 0;

  // clock / reset block
  always #5 clk = ~clk;

  screen_seq_ctrl #(
    .BLINK_FRAMES  (32),
    .RESULT_FRAMES (180)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vsync_in   (vsync_in),
    .btn_start  (btn_start),
    .game_over  (game_over),
    .screen_sel (screen_sel),
    .game_en    (game_en),
    .blink_on   (blink_on),
    .frame_tick (frame_tick)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one frame; optionally pulse game_over in the cycle the edge is seen.
  task automatic tick_frame(input logic [1:0] exp_sel, input bit go_same);
    logic [1:0] e;
    bit         got;
    exp_q.push_back(exp_sel);
    @(negedge clk);
    vsync_in = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      game_over = 1'b0;
      if (frame_tick) got = 1'b1;
      else if (go_same && i == 0) game_over = 1'b1;
    end
    game_over = 1'b0;
    check("tick_seen", 8'(got), 8'd1);
    e = exp_q.pop_front();
    check("screen_sel", 8'(screen_sel), 8'(e));
    check("game_en", 8'(game_en), 8'(e == SEL_GAME));
    @(negedge clk);
    check("tick_width", 8'(frame_tick), 8'd0);
    vsync_in = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic press();
    @(negedge clk);
    btn_start = 1'b1;
    repeat (4) @(negedge clk);
    btn_start = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_game_over();
    @(negedge clk);
    game_over = 1'b1;
    @(negedge clk);
    game_over = 1'b0;
  endtask

  initial begin
    rst = 1'b1; vsync_in = 1'b0; btn_start = 1'b0; game_over = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sel", 8'(screen_sel), 8'd0);
    check("rst_game_en", 8'(game_en), 8'd0);
    check("rst_blink", 8'(blink_on), 8'd1);
    check("rst_tick", 8'(frame_tick), 8'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // idle in START, blink toggles on the 32nd frame
    repeat (3) tick_frame(SEL_START, 1'b0);
    check("blink_f3", 8'(blink_on), 8'd1);
    repeat (28) tick_frame(SEL_START, 1'b0);
    check("blink_f31", 8'(blink_on), 8'd1);
    tick_frame(SEL_START, 1'b0);
    check("blink_f32", 8'(blink_on), 8'd0);

    // press mid-frame: no change until the frame edge
    press();
    check("pend_sel", 8'(screen_sel), 8'd0);
    check("pend_game_en", 8'(game_en), 8'd0);
    tick_frame(SEL_GAME, 1'b0);
    check("blink_game", 8'(blink_on), 8'd1);

    // press ignored in GAME
    press();
    tick_frame(SEL_GAME, 1'b0);

    // game_over coincident with frame_tick applies that cycle
    tick_frame(SEL_RESULT, 1'b1);
    check("blink_result", 8'(blink_on), 8'd1);

    // RESULT timeout after 180 frames
    repeat (179) tick_frame(SEL_RESULT, 1'b0);
    tick_frame(SEL_START, 1'b0);

    // pending game_over applied on the next frame
    press();
    tick_frame(SEL_GAME, 1'b0);
    pulse_game_over();
    repeat (3) @(negedge clk);
    check("go_pending_sel", 8'(screen_sel), 8'd1);
    tick_frame(SEL_RESULT, 1'b0);

    // press at frame 10 of RESULT returns at frame 11
    repeat (10) tick_frame(SEL_RESULT, 1'b0);
    press();
    tick_frame(SEL_START, 1'b0);

    // reset in GAME with a pending game_over
    press();
    tick_frame(SEL_GAME, 1'b0);
    pulse_game_over();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sel", 8'(screen_sel), 8'd0);
    check("midrst_game_en", 8'(game_en), 8'd0);
    check("midrst_blink", 8'(blink_on), 8'd1);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    tick_frame(SEL_START, 1'b0);

    // button held through reset must not start the game
    btn_start = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    tick_frame(SEL_START, 1'b0);
    btn_start = 1'b0;
    repeat (4) @(negedge clk);
    press();
    tick_frame(SEL_GAME, 1'b0);

    check("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no completion expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
